// File: rtl/program_counter.sv
// Program-counter register for the single-cycle RV32 core.
// PC advances by INCREMENT or by a signed offset on every edge where LOAD is high.
module program_counter #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      INCREMENT    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD,
  input  logic             PCSrc,
  input  logic [WIDTH-1:0] ImmExt,
  output logic [WIDTH-1:0] PC
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(INCREMENT);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] branch_pc;

  // Two separate adders keep the sequential path independent of ImmExt.
  assign seq_pc    = pc_q + STEP;
  assign branch_pc = pc_q + ImmExt;

  always_comb begin
    pc_d = pc_q;
    if (LOAD) begin
      pc_d = PCSrc ? branch_pc : seq_pc;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign PC = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Bench for program_counter: directed scenarios followed by random traffic,
// all checked against an arithmetic reference model of the next-PC rule.
module tb_program_counter;

  logic        CLK;
  logic        RST;
  logic        LOAD;
  logic        PCSrc;
  logic [31:0] ImmExt;
  logic [31:0] PC;

  logic [31:0] exp_pc;
  int unsigned n_checks;
  int unsigned n_fail;

  program_counter #(
    .WIDTH       (32),
    .RESET_VECTOR(32'h0000_0000),
    .INCREMENT   (4)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .LOAD  (LOAD),
    .PCSrc (PCSrc),
    .ImmExt(ImmExt),
    .PC    (PC)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: PC=%h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: unsigned sum in 64 bits, reduced modulo 2^32.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic ld,
                                             input logic src, input logic [31:0] imm);
    longint unsigned sum;
    if (!ld) return pc;
    sum = src ? (64'(pc) + 64'(imm)) : (64'(pc) + 64'd4);
    return 32'(sum % 64'h1_0000_0000);
  endfunction

  task automatic drive(input logic ld, input logic src, input logic [31:0] imm);
    LOAD   = ld;
    PCSrc  = src;
    ImmExt = imm;
  endtask

  task automatic cycle(input string tag);
    @(posedge CLK);
    if (RST) exp_pc = model_next(exp_pc, LOAD, PCSrc, ImmExt);
    else     exp_pc = 32'h0;
    #1;
    check_eq(tag, PC, exp_pc);
  endtask

  // Called just after an edge: reset must clear PC with no clock involved.
  task automatic pulse_reset(input string tag);
    RST = 1'b0;
    #2;
    exp_pc = 32'h0;
    check_eq(tag, PC, 32'h0);
    #1;
    RST = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_pc   = 32'h0;
    RST      = 1'b0;
    drive(1'b1, 1'b0, 32'd6);
    #1;
    check_eq("reset_no_edge", PC, 32'h0);
    repeat (3) cycle("reset_hold");
    check_eq("reset_hold_const", PC, 32'h0);

    RST = 1'b1;
    cycle("seq1");
    check_eq("seq1_const", PC, 32'd4);
    cycle("seq2");
    check_eq("seq2_const", PC, 32'd8);

    pulse_reset("reset_between_edges");
    cycle("seq_after_reset");
    check_eq("from4_const", PC, 32'd4);

    drive(1'b1, 1'b1, 32'd6);
    cycle("br10");
    cycle("br16");
    cycle("br22");
    cycle("br28");
    check_eq("br28_const", PC, 32'd28);
    drive(1'b1, 1'b1, 32'hFFFF_FFF8);
    cycle("br_neg");
    check_eq("br_neg_const", PC, 32'd20);
    drive(1'b1, 1'b1, 32'd8);
    cycle("br_back28");

    drive(1'b0, 1'b1, 32'd6);
    repeat (4) cycle("stall");
    check_eq("stall_const", PC, 32'd28);
    drive(1'b1, 1'b1, 32'd6);
    cycle("unstall");
    check_eq("unstall_const", PC, 32'd34);

    drive(1'b1, 1'b1, 32'hFFFF_FFFC - 32'd34);
    cycle("to_top");
    check_eq("to_top_const", PC, 32'hFFFF_FFFC);
    drive(1'b1, 1'b0, 32'd0);
    cycle("wrap_seq");
    check_eq("wrap_seq_const", PC, 32'h0);
    drive(1'b1, 1'b1, 32'hFFFF_FFFC);
    cycle("to_top2");
    drive(1'b1, 1'b1, 32'd8);
    cycle("wrap_branch");
    check_eq("wrap_branch_const", PC, 32'd4);

    drive(1'b1, 1'b1, 32'd18);
    cycle("to22");
    check_eq("to22_const", PC, 32'd22);
    drive(1'b1, 1'b1, 32'h0000_0123);
    pulse_reset("reset_midrun");
    cycle("post_reset_branch");
    check_eq("post_reset_branch_const", PC, 32'h0000_0123);
    pulse_reset("reset_midrun2");
    drive(1'b1, 1'b0, 32'hxxxx_xxxx);
    cycle("seq_imm_x");
    check_eq("seq_imm_x_const", PC, 32'd4);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] imm;
      imm = $urandom;
      if ($urandom_range(0, 3) != 0) imm = 32'($signed(12'($urandom)));
      drive(($urandom_range(0, 4) != 0), 1'($urandom), imm);
      if ($urandom_range(0, 39) == 0) pulse_reset("rand_reset");
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- Program-counter register for the single-cycle 32-bit RISC-V core.
- Holds the address of the current instruction and drives the instruction memory.
- Each enabled clock edge advances the PC either:
  - sequentially (PC+4), or
  - by a branch/jump offset (PC+ImmExt) chosen by the control unit's PCSrc.
- LOAD acts as a write enable that can stall the PC.

Parameters:
- WIDTH, 32, address/datapath width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value while reset is asserted.
- INCREMENT, 4, sequential step in bytes.

Ports:
- CLK  input  1  system clock; rising-edge active.
- RST  input  1  asynchronous, active-low reset.
- LOAD  input  1  PC write enable; 1 = update on the edge, 0 = hold.
- PCSrc  input  1  next-PC select; 0 = PC+INCREMENT, 1 = PC+ImmExt.
- ImmExt  input  WIDTH  sign-extended immediate (branch/jump offset), two's complement.
- PC  output  WIDTH  current program counter (registered).

Behaviour:
- One clock domain (CLK). Reset is asynchronous and active-low (RST). Polarity and synchronicity are fixed.
- Reset:
  - RST=0 forces PC=RESET_VECTOR immediately, without waiting for a clock edge.
  - PC holds that value while RST=0, regardless of LOAD, PCSrc or ImmExt.
- Reset release: the first rising edge with RST=1 and LOAD=1 loads the next-PC value.
- Next-PC computation is combinational from the current PC register:
  - next = PCSrc ? (PC + ImmExt) : (PC + INCREMENT).
- Update rule, on each rising CLK edge with RST=1:
  - LOAD=1: PC <= next.
  - LOAD=0: PC unchanged.
- Latency: one cycle. A change on PCSrc/ImmExt/LOAD affects PC at the next rising edge only.
- PC is a pure register output with no combinational path from the inputs.
- Arithmetic:
  - WIDTH-bit modulo-2^WIDTH addition; carry-out is discarded.
  - Wrap-around is silent, e.g. 32'hFFFF_FFFC + 4 = 32'h0000_0000.
  - A negative ImmExt (two's complement) moves PC backwards through the same adder.
- Alignment: no masking or alignment checking. Misaligned results are stored as-is (e.g. 4+6 = 10).
- Simultaneous events:
  - RST=0 overrides LOAD/PCSrc on the same edge.
  - Reset asserted mid-operation clears PC asynchronously.
  - Deassertion near a clock edge must meet recovery timing. No synchronizer is inside the block.
- No X propagation from ImmExt when PCSrc=0: the sequential path must not depend on ImmExt.

Test Plan:
- Reset:
  - RST=0, LOAD=1, PCSrc=0, ImmExt=6, toggle clock.
  - PC=0 throughout.
  - Assert RST=0 between edges: PC=0 immediately, with no edge needed.
- Sequential step:
  - Release RST (=1), LOAD=1, PCSrc=0.
  - First edge -> PC=4; next edge -> PC=8.
- Branch offset:
  - From PC=4, set PCSrc=1, ImmExt=6.
  - Successive edges -> PC=10, 16, 22, 28.
  - ImmExt=-8 (32'hFFFF_FFF8) from PC=28 -> PC=20.
- Stall:
  - From PC=28, set LOAD=0 with PCSrc=1, ImmExt=6.
  - Four edges -> PC stays 28.
  - Set LOAD=1 -> next edge PC=34.
- Wrap-around:
  - Drive PC to 32'hFFFF_FFFC (via offset), PCSrc=0, LOAD=1.
  - Edge -> PC=0.
  - With PCSrc=1, ImmExt=8 from 32'hFFFF_FFFC -> PC=4.
- Reset mid-run:
  - While PC=22 and LOAD=1, pulse RST low for 3 ns between edges.
  - PC=0 immediately.
  - After release, the first edge gives PC=ImmExt (PCSrc=1) or 4 (PCSrc=0).
